// File: rtl/rf_bank_arbiter_pkg.sv
// rf_bank_arbiter_pkg
// Shared constants and register-number field helpers for the register-file
// bank arbiter. A 5-bit register number splits into a 2-bit bank select
// (low bits) and a 3-bit row within that bank.
package rf_bank_arbiter_pkg;

    localparam int NUM_BANKS = 4;
    localparam int BANK_BITS = 2;
    localparam int ROW_BITS  = 3;
    localparam int OCID_W    = 3;
    localparam int REG_W     = BANK_BITS + ROW_BITS;
    localparam int BANK_LSB  = 0;
    localparam int ROW_LSB   = BANK_BITS;

    function automatic logic [BANK_BITS-1:0] bank_of(input logic [REG_W-1:0] addr);
        return addr[BANK_LSB +: BANK_BITS];
    endfunction

    function automatic logic [ROW_BITS-1:0] row_of(input logic [REG_W-1:0] addr);
        return addr[ROW_LSB +: ROW_BITS];
    endfunction

endpackage

// File: rtl/rf_bank_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The search starts at ptr and walks
// upward, wrapping from N-1 back to 0; the first requester found wins.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index holding highest priority this cycle
//   grant - one-hot grant (all zero when nobody requests)
//   valid - high when some requester was granted
module rr_arbiter #(
    parameter int N     = 8,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PTR_W'((32'(ptr) + i) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_bank_arbiter.sv
// rf_bank_arbiter
// Arbitrates operand-collector reads and a single writeback onto four
// register-file banks. Each bank has its own round-robin pointer; a
// writeback always wins its bank for the cycle. Bank-side outputs are
// registered one cycle after the accepting edge.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   req_valid/req_addr   - per-collector read requests (5-bit reg numbers, flat)
//   req_ready            - combinational per-collector grant
//   wb_valid/addr/data   - writeback, always accepted
//   RF_Addr_b, ocid_out_b, RF_WR_b, WriteData_b - registered bank commands
//   rd_issued            - per-bank read-issued flag
//   conflict_cnt         - saturating count of cycles with a denied request
module rf_bank_arbiter
    import rf_bank_arbiter_pkg::*;
#(
    parameter int NUM_OC = 8,
    parameter int DATA_W = 256,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_OC-1:0]       req_valid,
    input  logic [REG_W*NUM_OC-1:0] req_addr,
    output logic [NUM_OC-1:0]       req_ready,
    input  logic                    wb_valid,
    input  logic [REG_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    output logic [ROW_BITS-1:0]     RF_Addr_0,
    output logic [ROW_BITS-1:0]     RF_Addr_1,
    output logic [ROW_BITS-1:0]     RF_Addr_2,
    output logic [ROW_BITS-1:0]     RF_Addr_3,
    output logic [OCID_W-1:0]       ocid_out_0,
    output logic [OCID_W-1:0]       ocid_out_1,
    output logic [OCID_W-1:0]       ocid_out_2,
    output logic [OCID_W-1:0]       ocid_out_3,
    output logic                    RF_WR_0,
    output logic                    RF_WR_1,
    output logic                    RF_WR_2,
    output logic                    RF_WR_3,
    output logic [DATA_W-1:0]       WriteData_0,
    output logic [DATA_W-1:0]       WriteData_1,
    output logic [DATA_W-1:0]       WriteData_2,
    output logic [DATA_W-1:0]       WriteData_3,
    output logic [NUM_BANKS-1:0]    rd_issued,
    output logic [CNT_W-1:0]        conflict_cnt
);

    logic [NUM_OC-1:0]    bank_req [NUM_BANKS];
    logic [NUM_OC-1:0]    bank_gnt [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_gv;
    logic [NUM_BANKS-1:0] wb_own;
    logic [OCID_W-1:0]    win_id   [NUM_BANKS];
    logic [ROW_BITS-1:0]  win_row  [NUM_BANKS];
    logic [NUM_OC-1:0]    gnt_all;
    logic                 denied;

    logic [OCID_W-1:0]    ptr_q    [NUM_BANKS];
    logic [ROW_BITS-1:0]  addr_q   [NUM_BANKS];
    logic [OCID_W-1:0]    ocid_q   [NUM_BANKS];
    logic [DATA_W-1:0]    wd_q     [NUM_BANKS];
    logic [NUM_BANKS-1:0] wr_q;
    logic [NUM_BANKS-1:0] rd_q;
    logic [CNT_W-1:0]     cnt_q;

    // Route each request to its bank; a bank claimed by the writeback sees
    // no read requests, which also keeps its pointer frozen.
    always_comb begin
        wb_own = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            wb_own[b]   = wb_valid && (bank_of(wb_addr) == BANK_BITS'(b));
            bank_req[b] = '0;
            for (int unsigned i = 0; i < NUM_OC; i++) begin
                bank_req[b][i] = req_valid[i] && !wb_own[b] &&
                                 (bank_of(req_addr[i*REG_W +: REG_W]) == BANK_BITS'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        rr_arbiter #(.N(NUM_OC), .PTR_W(OCID_W)) u_rr (
            .req   (bank_req[b]),
            .ptr   (ptr_q[b]),
            .grant (bank_gnt[b]),
            .valid (bank_gv[b])
        );
    end

    always_comb begin
        gnt_all = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            win_id[b]  = '0;
            win_row[b] = '0;
            gnt_all    = gnt_all | bank_gnt[b];
            for (int unsigned i = 0; i < NUM_OC; i++) begin
                if (bank_gnt[b][i]) begin
                    win_id[b]  = OCID_W'(i);
                    win_row[b] = row_of(req_addr[i*REG_W +: REG_W]);
                end
            end
        end
        denied    = |(req_valid & ~gnt_all);
        req_ready = rst_n ? gnt_all : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                ptr_q[b]  <= '0;
                addr_q[b] <= '0;
                ocid_q[b] <= '0;
                wd_q[b]   <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                wr_q[b] <= 1'b0;
                rd_q[b] <= 1'b0;
                if (wb_own[b]) begin
                    addr_q[b] <= row_of(wb_addr);
                    ocid_q[b] <= '0;
                    wd_q[b]   <= wb_data;
                    wr_q[b]   <= 1'b1;
                end else if (bank_gv[b]) begin
                    addr_q[b] <= win_row[b];
                    ocid_q[b] <= win_id[b];
                    rd_q[b]   <= 1'b1;
                    ptr_q[b]  <= (win_id[b] == OCID_W'(NUM_OC-1)) ? '0 : win_id[b] + OCID_W'(1);
                end
            end
            if (denied && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign RF_Addr_0    = addr_q[0];
    assign RF_Addr_1    = addr_q[1];
    assign RF_Addr_2    = addr_q[2];
    assign RF_Addr_3    = addr_q[3];
    assign ocid_out_0   = ocid_q[0];
    assign ocid_out_1   = ocid_q[1];
    assign ocid_out_2   = ocid_q[2];
    assign ocid_out_3   = ocid_q[3];
    assign WriteData_0  = wd_q[0];
    assign WriteData_1  = wd_q[1];
    assign WriteData_2  = wd_q[2];
    assign WriteData_3  = wd_q[3];
    assign RF_WR_0      = wr_q[0];
    assign RF_WR_1      = wr_q[1];
    assign RF_WR_2      = wr_q[2];
    assign RF_WR_3      = wr_q[3];
    assign rd_issued    = rd_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_bank_arbiter.sv
module tb_rf_bank_arbiter;

    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]    bank;
        logic          wr;
        logic [2:0]    row;
        logic [2:0]    ocid;
        logic [DW-1:0] data;
    } op_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    req_valid;
    logic [39:0]   req_addr;
    logic          wb_valid;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;

    logic [7:0]    req_ready, req_ready_s;
    logic [2:0]    RF_Addr_0, RF_Addr_1, RF_Addr_2, RF_Addr_3;
    logic [2:0]    ocid_out_0, ocid_out_1, ocid_out_2, ocid_out_3;
    logic          RF_WR_0, RF_WR_1, RF_WR_2, RF_WR_3;
    logic [DW-1:0] WriteData_0, WriteData_1, WriteData_2, WriteData_3;
    logic [3:0]    rd_issued;
    logic [15:0]   conflict_cnt;

    logic [2:0]    sa0, sa1, sa2, sa3, so0, so1, so2, so3;
    logic          sw0, sw1, sw2, sw3;
    logic [DW-1:0] sd0, sd1, sd2, sd3;
    logic [3:0]    rd_issued_s;
    logic [1:0]    conflict_cnt_s;

    logic [2:0]    obs_addr [4];
    logic [2:0]    obs_ocid [4];
    logic [DW-1:0] obs_wd   [4];
    logic [3:0]    wr_vec;

    op_t exp_q[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    always #5 clk = ~clk;

    rf_bank_arbiter #(.NUM_OC(8), .DATA_W(DW), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .RF_Addr_0(RF_Addr_0), .RF_Addr_1(RF_Addr_1), .RF_Addr_2(RF_Addr_2), .RF_Addr_3(RF_Addr_3),
        .ocid_out_0(ocid_out_0), .ocid_out_1(ocid_out_1), .ocid_out_2(ocid_out_2), .ocid_out_3(ocid_out_3),
        .RF_WR_0(RF_WR_0), .RF_WR_1(RF_WR_1), .RF_WR_2(RF_WR_2), .RF_WR_3(RF_WR_3),
        .WriteData_0(WriteData_0), .WriteData_1(WriteData_1),
        .WriteData_2(WriteData_2), .WriteData_3(WriteData_3),
        .rd_issued(rd_issued), .conflict_cnt(conflict_cnt)
    );

    rf_bank_arbiter #(.NUM_OC(8), .DATA_W(DW), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready_s), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .RF_Addr_0(sa0), .RF_Addr_1(sa1), .RF_Addr_2(sa2), .RF_Addr_3(sa3),
        .ocid_out_0(so0), .ocid_out_1(so1), .ocid_out_2(so2), .ocid_out_3(so3),
        .RF_WR_0(sw0), .RF_WR_1(sw1), .RF_WR_2(sw2), .RF_WR_3(sw3),
        .WriteData_0(sd0), .WriteData_1(sd1), .WriteData_2(sd2), .WriteData_3(sd3),
        .rd_issued(rd_issued_s), .conflict_cnt(conflict_cnt_s)
    );

    assign obs_addr[0] = RF_Addr_0;  assign obs_addr[1] = RF_Addr_1;
    assign obs_addr[2] = RF_Addr_2;  assign obs_addr[3] = RF_Addr_3;
    assign obs_ocid[0] = ocid_out_0; assign obs_ocid[1] = ocid_out_1;
    assign obs_ocid[2] = ocid_out_2; assign obs_ocid[3] = ocid_out_3;
    assign obs_wd[0]   = WriteData_0; assign obs_wd[1] = WriteData_1;
    assign obs_wd[2]   = WriteData_2; assign obs_wd[3] = WriteData_3;
    assign wr_vec      = {RF_WR_3, RF_WR_2, RF_WR_1, RF_WR_0};

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        wb_valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        op_t op;
        logic [3:0] erd, ewr;
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '1;
        wb_valid  = 1'b1;
        wb_addr   = 5'd6;
        wb_data   = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) req_addr[i*5 +: 5] = 5'(i);
        #1;
        n_chk++;
        if (req_ready !== 8'h00) $display("FAIL reset_ready: got %h want 00", req_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if ({RF_Addr_0, RF_Addr_1, RF_Addr_2, RF_Addr_3, ocid_out_0, ocid_out_1, ocid_out_2,
             ocid_out_3, wr_vec, WriteData_0, WriteData_1, WriteData_2, WriteData_3,
             rd_issued, conflict_cnt, conflict_cnt_s} !== '0)
            $display("FAIL reset_outputs: got wr %b rd %b cnt %0d wd0 %h want all zero",
                     wr_vec, rd_issued, conflict_cnt, WriteData_0);
        else n_pass++;
        // first cycle out of reset: banks b requested by b and b+4, pointer 0 -> b wins
        @(negedge clk);
        rst_n    = 1'b1;
        wb_valid = 1'b0;
        #1;
        n_chk++;
        if (req_ready !== 8'h0F) $display("FAIL reset_first_ready: got %h want 0f", req_ready);
        else n_pass++;
        for (int b = 0; b < 4; b++) exp_q.push_back('{2'(b), 1'b0, 3'd0, 3'(b), '0});
        @(posedge clk); #1;
        erd = '0; ewr = '0;
        while (exp_q.size() > 0) begin
            op = exp_q.pop_front();
            if (op.wr) ewr[op.bank] = 1'b1; else erd[op.bank] = 1'b1;
            n_chk++;
            if (obs_addr[op.bank] !== op.row || obs_ocid[op.bank] !== op.ocid)
                $display("FAIL reset_bank%0d: got row %0d ocid %0d want row %0d ocid %0d",
                         op.bank, obs_addr[op.bank], obs_ocid[op.bank], op.row, op.ocid);
            else n_pass++;
        end
        n_chk++;
        if (rd_issued !== erd || wr_vec !== ewr)
            $display("FAIL reset_flags: got rd %b wr %b want rd %b wr %b", rd_issued, wr_vec, erd, ewr);
        else n_pass++;
        n_chk++;
        if (conflict_cnt !== 16'd1) $display("FAIL reset_conflict: got %0d want 1", conflict_cnt);
        else n_pass++;
    endtask

    task automatic test_no_conflict();
        op_t op;
        logic [3:0] erd, ewr;
        do_reset();
        @(negedge clk);
        req_valid = 8'h0F;
        for (int i = 0; i < 4; i++) req_addr[i*5 +: 5] = 5'(i);
        #1;
        n_chk++;
        if (req_ready !== 8'h0F) $display("FAIL noconf_ready: got %h want 0f", req_ready);
        else n_pass++;
        for (int b = 0; b < 4; b++) exp_q.push_back('{2'(b), 1'b0, 3'd0, 3'(b), '0});
        @(posedge clk); #1;
        req_valid = '0;
        erd = '0; ewr = '0;
        while (exp_q.size() > 0) begin
            op = exp_q.pop_front();
            if (op.wr) ewr[op.bank] = 1'b1; else erd[op.bank] = 1'b1;
            n_chk++;
            if (obs_addr[op.bank] !== op.row || obs_ocid[op.bank] !== op.ocid)
                $display("FAIL noconf_bank%0d: got row %0d ocid %0d want row %0d ocid %0d",
                         op.bank, obs_addr[op.bank], obs_ocid[op.bank], op.row, op.ocid);
            else n_pass++;
        end
        n_chk++;
        if (rd_issued !== erd || wr_vec !== ewr)
            $display("FAIL noconf_flags: got rd %b wr %b want rd %b wr %b", rd_issued, wr_vec, erd, ewr);
        else n_pass++;
        n_chk++;
        if (conflict_cnt !== 16'd0) $display("FAIL noconf_conflict: got %0d want 0", conflict_cnt);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        op_t op;
        logic [3:0] erd, ewr;
        int unsigned win [3] = '{2, 5, 7};
        logic [7:0] rv = 8'b1010_0100;
        do_reset();
        for (int i = 0; i < 8; i++) req_addr[i*5 +: 5] = 5'd4;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            req_valid = rv;
            #1;
            n_chk++;
            if (req_ready !== (8'h01 << win[s]))
                $display("FAIL rr_ready%0d: got %h want %h", s, req_ready, 8'h01 << win[s]);
            else n_pass++;
            exp_q.push_back('{2'd0, 1'b0, 3'd1, 3'(win[s]), '0});
            @(posedge clk); #1;
            erd = '0; ewr = '0;
            while (exp_q.size() > 0) begin
                op = exp_q.pop_front();
                if (op.wr) ewr[op.bank] = 1'b1; else erd[op.bank] = 1'b1;
                n_chk++;
                if (obs_addr[op.bank] !== op.row || obs_ocid[op.bank] !== op.ocid)
                    $display("FAIL rr_bank%0d_step%0d: got row %0d ocid %0d want row %0d ocid %0d",
                             op.bank, s, obs_addr[op.bank], obs_ocid[op.bank], op.row, op.ocid);
                else n_pass++;
            end
            n_chk++;
            if (rd_issued !== erd || wr_vec !== ewr)
                $display("FAIL rr_flags%0d: got rd %b wr %b want rd %b wr %b", s, rd_issued, wr_vec, erd, ewr);
            else n_pass++;
            rv[win[s]] = 1'b0;
        end
        @(negedge clk);
        req_valid = '0;
        n_chk++;
        if (conflict_cnt !== 16'd2) $display("FAIL rr_conflict: got %0d want 2", conflict_cnt);
        else n_pass++;
    endtask

    task automatic test_write_priority();
        op_t op;
        logic [3:0] erd, ewr;
        logic [DW-1:0] d = $urandom();
        logic [7:0] exp_rdy [2] = '{8'h00, 8'h02};
        do_reset();
        req_addr[5 +: 5] = 5'd13;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            req_valid = 8'h02;
            wb_valid  = (s == 0);
            wb_addr   = 5'd9;
            wb_data   = d;
            #1;
            n_chk++;
            if (req_ready !== exp_rdy[s])
                $display("FAIL wb_ready%0d: got %h want %h", s, req_ready, exp_rdy[s]);
            else n_pass++;
            if (s == 0) exp_q.push_back('{2'd1, 1'b1, 3'd2, 3'd0, d});
            else        exp_q.push_back('{2'd1, 1'b0, 3'd3, 3'd1, '0});
            @(posedge clk); #1;
            erd = '0; ewr = '0;
            while (exp_q.size() > 0) begin
                op = exp_q.pop_front();
                if (op.wr) ewr[op.bank] = 1'b1; else erd[op.bank] = 1'b1;
                n_chk++;
                if (obs_addr[op.bank] !== op.row || obs_ocid[op.bank] !== op.ocid ||
                    (op.wr && obs_wd[op.bank] !== op.data))
                    $display("FAIL wb_bank%0d_step%0d: got row %0d ocid %0d data %h want row %0d ocid %0d data %h",
                             op.bank, s, obs_addr[op.bank], obs_ocid[op.bank], obs_wd[op.bank],
                             op.row, op.ocid, op.data);
                else n_pass++;
            end
            n_chk++;
            if (rd_issued !== erd || wr_vec !== ewr)
                $display("FAIL wb_flags%0d: got rd %b wr %b want rd %b wr %b", s, rd_issued, wr_vec, erd, ewr);
            else n_pass++;
        end
        @(negedge clk);
        req_valid = '0;
        n_chk++;
        if (conflict_cnt !== 16'd1) $display("FAIL wb_conflict: got %0d want 1", conflict_cnt);
        else n_pass++;
    endtask

    task automatic test_pointer_wrap();
        op_t op;
        logic [3:0] erd, ewr;
        logic [7:0] rvs [4] = '{8'h40, 8'h81, 8'h01, 8'h03};
        int unsigned win [4] = '{6, 7, 0, 1};
        do_reset();
        for (int i = 0; i < 8; i++) req_addr[i*5 +: 5] = 5'd0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            req_valid = rvs[s];
            #1;
            n_chk++;
            if (req_ready !== (8'h01 << win[s]))
                $display("FAIL wrap_ready%0d: got %h want %h", s, req_ready, 8'h01 << win[s]);
            else n_pass++;
            exp_q.push_back('{2'd0, 1'b0, 3'd0, 3'(win[s]), '0});
            @(posedge clk); #1;
            erd = '0; ewr = '0;
            while (exp_q.size() > 0) begin
                op = exp_q.pop_front();
                if (op.wr) ewr[op.bank] = 1'b1; else erd[op.bank] = 1'b1;
                n_chk++;
                if (obs_addr[op.bank] !== op.row || obs_ocid[op.bank] !== op.ocid)
                    $display("FAIL wrap_bank%0d_step%0d: got row %0d ocid %0d want row %0d ocid %0d",
                             op.bank, s, obs_addr[op.bank], obs_ocid[op.bank], op.row, op.ocid);
                else n_pass++;
            end
            n_chk++;
            if (rd_issued !== erd || wr_vec !== ewr)
                $display("FAIL wrap_flags%0d: got rd %b wr %b want rd %b wr %b", s, rd_issued, wr_vec, erd, ewr);
            else n_pass++;
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 8; i++) req_addr[i*5 +: 5] = 5'd0;
        @(negedge clk);
        req_valid = 8'h11;
        for (int s = 0; s < 5; s++) begin
            #1;
            n_chk++;
            if (req_ready_s !== ((s % 2 == 0) ? 8'h01 : 8'h10))
                $display("FAIL sat_ready%0d: got %h want %h", s, req_ready_s,
                         (s % 2 == 0) ? 8'h01 : 8'h10);
            else n_pass++;
            @(posedge clk); #1;
            exp_cnt = (s >= 2) ? 2'd3 : 2'(s + 1);
            n_chk++;
            if (conflict_cnt_s !== exp_cnt)
                $display("FAIL sat_cnt%0d: got %0d want %0d", s, conflict_cnt_s, exp_cnt);
            else n_pass++;
            @(negedge clk);
        end
        n_chk++;
        if (conflict_cnt !== 16'd5) $display("FAIL sat_wide_cnt: got %0d want 5", conflict_cnt);
        else n_pass++;
        req_valid = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        test_reset();
        test_no_conflict();
        test_round_robin();
        test_write_priority();
        test_pointer_wrap();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
